// File: rtl/qgate_pair_sched.sv
// qgate_pair_sched: applies a single-qubit 2x2 complex gate U (Q16.16) in place
// to an NQ-qubit state vector stored in an external synchronous RAM.
// One complex_mult is shared across the four products of each amplitude pair.
// Optional build macro: QGATE_CTRL_EN adds a control qubit (ctrl_en, ctrl_q)
// that skips pairs whose i0 has the control bit clear.

// Q16.16 complex multiplier, purely combinational; operands and result are {re,im}.
module complex_mult (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] p
);
    logic signed [31:0] ar, ai, br, bi;
    logic signed [63:0] rr, ii, ri, ir;

    // Full-precision partial products, then rescale by 2^16 and truncate to 32b.
    always_comb begin
        ar = a[63:32];
        ai = a[31:0];
        br = b[63:32];
        bi = b[31:0];
        rr = 64'(ar) * 64'(br);
        ii = 64'(ai) * 64'(bi);
        ri = 64'(ar) * 64'(bi);
        ir = 64'(ai) * 64'(br);
        p  = {32'((rr - ii) >>> 16), 32'((ri + ir) >>> 16)};
    end
endmodule

module qgate_pair_sched #(
    parameter  int NQ = 3,
    parameter  int AW = NQ,
    localparam int TW = (NQ > 1) ? $clog2(NQ) : 1,
    localparam int KW = (NQ > 1) ? NQ - 1 : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TW-1:0]   target,
    input  logic [255:0]    u_mat,
`ifdef QGATE_CTRL_EN
    input  logic            ctrl_en,
    input  logic [TW-1:0]   ctrl_q,
`endif
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_re,
    input  logic [63:0]     mem_rdata,
    output logic            mem_we,
    output logic [63:0]     mem_wdata
);
    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_M0, S_M1, S_M2, S_M3, S_WR0, S_WR1, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   tgt_q, tgt_d;
    logic [255:0]    u_q, u_d;
    logic [63:0]     a0_q, a0_d, a1_q, a1_d;
    logic [63:0]     acc0_q, acc0_d, acc1_q, acc1_d;
    logic            ovf_q, ovf_d, err_q, err_d;
`ifdef QGATE_CTRL_EN
    logic            ctrl_en_q, ctrl_en_d;
    logic [TW-1:0]   ctrl_q_q, ctrl_q_d;
`endif

    logic [AW-1:0]   k_ext, low_mask, i0, i1;
    logic [63:0]     mul_u, mul_a, prod, add_base;
    logic [31:0]     sum_r, sum_i;
    logic            add_ovf, last_pair, skip_pair, ctrl_ok, start_ok;

    // Pair addresses: i0 is k with a zero inserted at the target bit, i1 sets that bit.
    assign k_ext     = AW'(k_q);
    assign low_mask  = (AW'(1) << tgt_q) - AW'(1);
    assign i0        = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    assign i1        = i0 | (AW'(1) << tgt_q);
    assign last_pair = &k_q;

`ifdef QGATE_CTRL_EN
    assign ctrl_ok   = !ctrl_en || ((ctrl_q != target) && (int'(ctrl_q) < NQ));
    assign skip_pair = ctrl_en_q && !i0[ctrl_q_q];
`else
    assign ctrl_ok   = 1'b1;
    assign skip_pair = 1'b0;
`endif
    assign start_ok  = (int'(target) < NQ) && ctrl_ok;

    // Multiplier operand mux: M0 u00*a0, M1 u01*a1, M2 u10*a0, M3 u11*a1.
    always_comb begin
        mul_u = u_q[255:192];
        mul_a = a0_q;
        unique case (state_q)
            S_M1:    begin mul_u = u_q[191:128]; mul_a = a1_q; end
            S_M2:    begin mul_u = u_q[127:64];  mul_a = a0_q; end
            S_M3:    begin mul_u = u_q[63:0];    mul_a = a1_q; end
            default: ;
        endcase
    end

    complex_mult u_cmul (
        .a (mul_u),
        .b (mul_a),
        .p (prod)
    );

    // Wrapping accumulate with per-component signed overflow detection.
    always_comb begin
        add_base = (state_q == S_M3) ? acc1_q : acc0_q;
        sum_r    = add_base[63:32] + prod[63:32];
        sum_i    = add_base[31:0]  + prod[31:0];
        add_ovf  = ((add_base[63] == prod[63]) && (sum_r[31] != add_base[63])) ||
                   ((add_base[31] == prod[31]) && (sum_i[31] != add_base[31]));
    end

    // Next-state, datapath updates and memory/handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        tgt_d     = tgt_q;
        u_d       = u_q;
        a0_d      = a0_q;
        a1_d      = a1_q;
        acc0_d    = acc0_q;
        acc1_d    = acc1_q;
        ovf_d     = ovf_q;
        err_d     = 1'b0;
`ifdef QGATE_CTRL_EN
        ctrl_en_d = ctrl_en_q;
        ctrl_q_d  = ctrl_q_q;
`endif
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        tgt_d     = target;
                        u_d       = u_mat;
                        ovf_d     = 1'b0;
                        k_d       = '0;
`ifdef QGATE_CTRL_EN
                        ctrl_en_d = ctrl_en;
                        ctrl_q_d  = ctrl_q;
`endif
                        state_d   = S_RD0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD0: begin
                busy = 1'b1;
                if (skip_pair) begin
                    if (last_pair) state_d = S_FIN;
                    else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_RD0;
                    end
                end else begin
                    mem_addr = i0;
                    mem_re   = 1'b1;
                    state_d  = S_RD1;
                end
            end
            S_RD1: begin
                busy     = 1'b1;
                mem_addr = i1;
                mem_re   = 1'b1;
                a0_d     = mem_rdata;
                state_d  = S_M0;
            end
            S_M0: begin
                busy    = 1'b1;
                a1_d    = mem_rdata;
                acc0_d  = prod;
                state_d = S_M1;
            end
            S_M1: begin
                busy    = 1'b1;
                acc0_d  = {sum_r, sum_i};
                ovf_d   = ovf_q | add_ovf;
                state_d = S_M2;
            end
            S_M2: begin
                busy    = 1'b1;
                acc1_d  = prod;
                state_d = S_M3;
            end
            S_M3: begin
                busy    = 1'b1;
                acc1_d  = {sum_r, sum_i};
                ovf_d   = ovf_q | add_ovf;
                state_d = S_WR0;
            end
            S_WR0: begin
                busy      = 1'b1;
                mem_addr  = i0;
                mem_we    = 1'b1;
                mem_wdata = acc0_q;
                state_d   = S_WR1;
            end
            S_WR1: begin
                busy      = 1'b1;
                mem_addr  = i1;
                mem_we    = 1'b1;
                mem_wdata = acc1_q;
                if (last_pair) state_d = S_FIN;
                else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_RD0;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;
    assign ovf = ovf_q;

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Datapath latches: U, target, amplitudes and accumulators.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always loaded before use and never reach an output in IDLE.
        tgt_q     <= tgt_d;
        u_q       <= u_d;
        a0_q      <= a0_d;
        a1_q      <= a1_d;
        acc0_q    <= acc0_d;
        acc1_q    <= acc1_d;
`ifdef QGATE_CTRL_EN
        ctrl_en_q <= ctrl_en_d;
        ctrl_q_q  <= ctrl_q_d;
`endif
    end
endmodule

// File: tb/tb_qgate_pair_sched.sv
// Testbench for qgate_pair_sched: a 2-qubit and a 3-qubit instance, each with a
// behavioural synchronous RAM; expected writes go into a queue at stimulus time
// and a monitor pops and compares them whenever the DUT writes.
module tb_qgate_pair_sched;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [255:0] U_ID = {ONE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ONE, 32'd0};
    localparam logic [255:0] U_X  = {32'd0, 32'd0, ONE, 32'd0, ONE, 32'd0, 32'd0, 32'd0};
    localparam logic [255:0] U_DI = {ONE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ONE};
    localparam logic [255:0] U_OV = {32'h7FFF_0000, 32'd0, 32'h7FFF_0000, 32'd0,
                                     32'd0, 32'd0, 32'd0, 32'd0};
    localparam logic [63:0]  OVV  = {32'hFFFE_0000, 32'd0};

    typedef struct packed { logic [7:0] addr; logic [63:0] data; } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] amp(input int re, input int im);
        return {32'(re * 65536), 32'(im * 65536)};
    endfunction

    // ---------------- 2-qubit instance ----------------
    logic          rst2, start2, busy2, done2, err2, ovf2, re2, we2;
    logic [0:0]    target2, cq2;
    logic          cen2;
    logic [255:0]  u2;
    logic [1:0]    addr2;
    logic [63:0]   rdata2, wdata2;
    logic [63:0]   ram2 [4];
    logic          ld2;
    logic [1:0]    ld2_addr;
    logic [63:0]   ld2_data;
    wr_t           q2[$];
    wr_t           e2;

    qgate_pair_sched #(.NQ(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .target(target2), .u_mat(u2),
`ifdef QGATE_CTRL_EN
        .ctrl_en(cen2), .ctrl_q(cq2),
`endif
        .busy(busy2), .done(done2), .err(err2), .ovf(ovf2),
        .mem_addr(addr2), .mem_re(re2), .mem_rdata(rdata2), .mem_we(we2), .mem_wdata(wdata2)
    );

    always @(posedge clk) begin
        if (re2) rdata2 <= ram2[addr2];
        if (we2) ram2[addr2] <= wdata2;
        else if (ld2) ram2[ld2_addr] <= ld2_data;
    end

    // ---------------- 3-qubit instance ----------------
    logic          rst3, start3, busy3, done3, err3, ovf3, re3, we3;
    logic [1:0]    target3, cq3;
    logic          cen3;
    logic [255:0]  u3;
    logic [2:0]    addr3;
    logic [63:0]   rdata3, wdata3;
    logic [63:0]   ram3 [8];
    logic          ld3;
    logic [2:0]    ld3_addr;
    logic [63:0]   ld3_data;
    wr_t           q3[$];
    wr_t           e3;

    qgate_pair_sched #(.NQ(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .target(target3), .u_mat(u3),
`ifdef QGATE_CTRL_EN
        .ctrl_en(cen3), .ctrl_q(cq3),
`endif
        .busy(busy3), .done(done3), .err(err3), .ovf(ovf3),
        .mem_addr(addr3), .mem_re(re3), .mem_rdata(rdata3), .mem_we(we3), .mem_wdata(wdata3)
    );

    always @(posedge clk) begin
        if (re3) rdata3 <= ram3[addr3];
        if (we3) ram3[addr3] <= wdata3;
        else if (ld3) ram3[ld3_addr] <= ld3_data;
    end

    // ---------------- monitors: bus discipline and write scoreboard ----------------
    always @(negedge clk) begin
        if (!rst2) begin
            check("re_we_excl2", 64'(re2 & we2), 64'd0);
            if (!re2 && !we2) check("addr_idle2", 64'(addr2), 64'd0);
            if (we2) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write2 got addr=%0d data=%h expected=no write", addr2, wdata2);
                end else begin
                    e2 = q2.pop_front();
                    check("wr_addr2", 64'(addr2), 64'(e2.addr));
                    check("wr_data2", wdata2, e2.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3) begin
            check("re_we_excl3", 64'(re3 & we3), 64'd0);
            if (!re3 && !we3) check("addr_idle3", 64'(addr3), 64'd0);
            if (we3) begin
                if (q3.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write3 got addr=%0d data=%h expected=no write", addr3, wdata3);
                end else begin
                    e3 = q3.pop_front();
                    check("wr_addr3", 64'(addr3), 64'(e3.addr));
                    check("wr_data3", wdata3, e3.data);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic load2(input logic [3:0][63:0] v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ld2 = 1'b1; ld2_addr = 2'(i); ld2_data = v[i];
        end
        @(negedge clk); ld2 = 1'b0;
    endtask

    task automatic load3(input logic [7:0][63:0] v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); ld3 = 1'b1; ld3_addr = 3'(i); ld3_data = v[i];
        end
        @(negedge clk); ld3 = 1'b0;
    endtask

    // ord: nibble i holds the address of the i-th expected write.
    task automatic expect2(input logic [31:0] ord, input int n, input logic [3:0][63:0] fin);
        for (int i = 0; i < n; i++) q2.push_back({8'(ord[4*i +: 4]), fin[ord[4*i +: 2]]});
    endtask

    task automatic expect3(input logic [31:0] ord, input int n, input logic [7:0][63:0] fin);
        for (int i = 0; i < n; i++) q3.push_back({8'(ord[4*i +: 4]), fin[ord[4*i +: 3]]});
    endtask

    task automatic ram_check2(input string name, input logic [3:0][63:0] fin);
        for (int i = 0; i < 4; i++) check(name, ram2[i], fin[i]);
    endtask

    task automatic ram_check3(input string name, input logic [7:0][63:0] fin);
        for (int i = 0; i < 8; i++) check(name, ram3[i], fin[i]);
    endtask

    // Returns at the negedge of cycle 1 (first cycle after the start edge).
    task automatic start_dut2(input logic t, input logic [255:0] u, input logic ce, input logic cq);
        @(negedge clk); start2 = 1'b1; target2 = t; u2 = u; cen2 = ce; cq2 = cq;
        @(negedge clk); start2 = 1'b0;
    endtask

    task automatic start_dut3(input logic [1:0] t, input logic [255:0] u);
        @(negedge clk); start3 = 1'b1; target3 = t; u3 = u; cen3 = 1'b0; cq3 = 2'd0;
        @(negedge clk); start3 = 1'b0;
    endtask

    task automatic wait_done2(input int cyc0, input int exp_cyc, input string name);
        int c = cyc0;
        while (!done2 && c < 400) begin @(negedge clk); c++; end
        check(name, 64'(c), 64'(exp_cyc));
    endtask

    task automatic wait_done3(input int cyc0, input int exp_cyc, input string name);
        int c = cyc0;
        while (!done3 && c < 400) begin @(negedge clk); c++; end
        check(name, 64'(c), 64'(exp_cyc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- directed stimulus ----------------
    logic [3:0][63:0] init2, fin2;
    logic [7:0][63:0] init3, fin3;

    initial begin
        rst2 = 1'b1; rst3 = 1'b1;
        start2 = 1'b0; start3 = 1'b0; target2 = '0; target3 = '0;
        u2 = '0; u3 = '0; cen2 = 1'b0; cq2 = '0; cen3 = 1'b0; cq3 = '0;
        ld2 = 1'b0; ld2_addr = '0; ld2_data = '0; ld3 = 1'b0; ld3_addr = '0; ld3_data = '0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("reset_flags2", 64'({busy2, done2, err2, ovf2, re2, we2}), 64'd0);
        check("reset_wdata2", wdata2, 64'd0);
        check("reset_flags3", 64'({busy3, done3, err3, ovf3, re3, we3}), 64'd0);
        check("reset_wdata3", wdata3, 64'd0);

        // Identity, target 1, NQ=2: RAM unchanged, writes 0,2,1,3, done at cycle 17.
        init2[0] = amp(1, 0); init2[1] = amp(2, 0); init2[2] = amp(3, 0); init2[3] = amp(4, 0);
        load2(init2);
        expect2(32'h3120, 4, init2);
        start_dut2(1'b1, U_ID, 1'b0, 1'b0);
        check("busy_after_start2", 64'(busy2), 64'd1);
        wait_done2(1, 17, "done_lat_identity2");
        check("ovf_identity2", 64'(ovf2), 64'd0);
        @(negedge clk);
        check("busy_after_done2", 64'(busy2), 64'd0);
        ram_check2("ram_identity2", init2);

        // Pauli-X, target 0: {A,B,C,D} -> {B,A,D,C}, writes 0,1,2,3.
        init2[0] = amp(5, 0); init2[1] = amp(-3, 0); init2[2] = {32'h0000_8000, 32'd0}; init2[3] = amp(0, 7);
        fin2[0]  = amp(-3, 0); fin2[1] = amp(5, 0); fin2[2] = amp(0, 7); fin2[3] = {32'h0000_8000, 32'd0};
        load2(init2);
        expect2(32'h3210, 4, fin2);
        start_dut2(1'b0, U_X, 1'b0, 1'b0);
        wait_done2(1, 17, "done_lat_paulix2");
        @(negedge clk);
        ram_check2("ram_paulix2", fin2);

        // Overflow: 32767.0 + 32767.0 wraps; ovf rises after M1 and is sticky.
        for (int i = 0; i < 4; i++) init2[i] = amp(1, 0);
        fin2[0] = OVV; fin2[1] = 64'd0; fin2[2] = OVV; fin2[3] = 64'd0;
        load2(init2);
        expect2(32'h3210, 4, fin2);
        start_dut2(1'b0, U_OV, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_during_m1", 64'(ovf2), 64'd0);
        @(negedge clk);
        check("ovf_after_m1", 64'(ovf2), 64'd1);
        wait_done2(5, 17, "done_lat_ovf2");
        check("ovf_at_done", 64'(ovf2), 64'd1);
        repeat (2) @(negedge clk);
        check("ovf_sticky_idle", 64'(ovf2), 64'd1);
        ram_check2("ram_ovf2", fin2);

        // Next accepted start clears ovf; identity leaves RAM unchanged.
        expect2(32'h3120, 4, fin2);
        start_dut2(1'b1, U_ID, 1'b0, 1'b0);
        check("ovf_cleared_by_start", 64'(ovf2), 64'd0);
        wait_done2(1, 17, "done_lat_clear2");
        check("ovf_identity_after", 64'(ovf2), 64'd0);
        @(negedge clk);

        // Reset during M2 of pair 1: only pair 0 written, everything idle next cycle.
        load2(init2);
        fin2[0] = OVV; fin2[1] = 64'd0; fin2[2] = amp(1, 0); fin2[3] = amp(1, 0);
        expect2(32'h10, 2, fin2);
        start_dut2(1'b0, U_OV, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        check("rst_mid_flags", 64'({busy2, done2, err2, ovf2, re2, we2}), 64'd0);
        check("rst_mid_addr", 64'(addr2), 64'd0);
        check("rst_mid_wdata", wdata2, 64'd0);
        rst2 = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_idle_busy", 64'(busy2), 64'd0);
        ram_check2("ram_after_rst2", fin2);

        // NQ=3, target 2, diag(1, i): amplitudes 4..7 (r,i) -> (-i,r).
        init3[0] = amp(1, 0);  init3[1] = amp(0, 1);  init3[2] = amp(2, 3);  init3[3] = amp(-1, 5);
        init3[4] = amp(3, 4);  init3[5] = amp(-2, 0); init3[6] = amp(0, -6); init3[7] = amp(7, -1);
        fin3 = init3;
        fin3[4] = amp(-4, 3); fin3[5] = amp(0, -2); fin3[6] = amp(6, 0); fin3[7] = amp(1, 7);
        load3(init3);
        expect3(32'h7362_5140, 8, fin3);
        start_dut3(2'd2, U_DI);
        wait_done3(1, 33, "done_lat_diag3");
        check("ovf_diag3", 64'(ovf3), 64'd0);
        @(negedge clk);
        ram_check3("ram_diag3", fin3);

        // target >= NQ: err pulse, no bus activity, busy stays low.
        start_dut3(2'd3, U_ID);
        check("err_pulse", 64'({err3, busy3}), 64'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_reject_idle", 64'({err3, busy3, re3, we3}), 64'd0);
        end

        // Starts while busy (valid and invalid target) are ignored without err.
        expect3(32'h7654_3210, 8, fin3);
        start_dut3(2'd0, U_ID);
        @(negedge clk); start3 = 1'b1; target3 = 2'd1; u3 = U_X;
        @(negedge clk); target3 = 2'd3;
        @(negedge clk); start3 = 1'b0;
        begin
            int c = 4;
            int err_seen = 0;
            while (!done3 && c < 400) begin
                if (err3) err_seen++;
                @(negedge clk); c++;
            end
            check("err_while_busy", 64'(err_seen), 64'd0);
            check("done_lat_busy3", 64'(c), 64'd33);
        end
        @(negedge clk);
        ram_check3("ram_busy_ignored3", fin3);

`ifdef QGATE_CTRL_EN
        // Controlled gate: ctrl_q == target is rejected.
        start_dut2(1'b0, U_X, 1'b1, 1'b0);
        check("ctrl_err_pulse", 64'({err2, busy2}), 64'b10);
        @(negedge clk);
        // ctrl_q=1, target 0: pair (0,1) skipped, only (2,3) swapped, done at cycle 10.
        init2[0] = amp(5, 0); init2[1] = amp(-3, 0); init2[2] = amp(2, 0); init2[3] = amp(0, 7);
        fin2[0] = amp(5, 0); fin2[1] = amp(-3, 0); fin2[2] = amp(0, 7); fin2[3] = amp(2, 0);
        load2(init2);
        expect2(32'h32, 2, fin2);
        start_dut2(1'b0, U_X, 1'b1, 1'b1);
        check("ctrl_skip_no_read", 64'(re2), 64'd0);
        wait_done2(1, 10, "done_lat_ctrl2");
        @(negedge clk);
        ram_check2("ram_ctrl2", fin2);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty2", 64'(q2.size()), 64'd0);
        check("sb_empty3", 64'(q3.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
